// File: rtl/vga_text_overlay_pkg.sv
// Shared constants, types and helpers for the character-cell text overlay.
// Cell word layout: {blink, fg_idx[1:0], char[6:0]}.
package vga_text_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 16;

  localparam int CHAR_LSB   = 0;
  localparam int CHAR_W     = 7;
  localparam int FG_LSB     = 7;
  localparam int BLINK_BIT  = 9;
  localparam int CELL_BITS  = 10;

  localparam logic [11:0] PAL_GREEN  = 12'h0F0;
  localparam logic [11:0] PAL_RED    = 12'h00F;
  localparam logic [11:0] PAL_WHITE  = 12'hFFF;
  localparam logic [11:0] PAL_YELLOW = 12'h0FF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Per-pixel control travelling alongside the buffer/font fetch
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic       in_area;
    logic [2:0] px;
    logic [3:0] line;
  } pix_ctl_t;

  function automatic logic [11:0] palette(input logic [1:0] idx);
    logic [11:0] c;
    case (idx)
      2'd0:    c = PAL_GREEN;
      2'd1:    c = PAL_RED;
      2'd2:    c = PAL_WHITE;
      2'd3:    c = PAL_YELLOW;
      default: c = PAL_GREEN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_text_overlay_if.sv
// Cell-write bus: the producer drives a cell write, the overlay answers ready/error.
interface vga_text_overlay_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [6:0] wr_char;
  logic [2:0] wr_attr;
  logic       wr_err;

  modport master (
    output wr_valid, wr_col, wr_row, wr_char, wr_attr,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_char, wr_attr,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/font_rom.sv
// Font ROM, address {char[6:0], line[3:0]}, MSB = leftmost pixel, LAT-cycle read.
// Carries 'A' (0x41) and a solid block (0x7F); all other codes render empty.
module font_rom #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  function automatic logic [7:0] glyph(input logic [10:0] a);
    logic [7:0] g;
    case (a)
      11'h412: g = 8'h10;
      11'h413: g = 8'h38;
      11'h414: g = 8'h6C;
      11'h415: g = 8'hC6;
      11'h416: g = 8'hC6;
      11'h417: g = 8'hFE;
      11'h418: g = 8'hC6;
      11'h419: g = 8'hC6;
      11'h41A: g = 8'hC6;
      11'h41B: g = 8'hC6;
      default: g = (a[10:4] == 7'h7F) ? 8'hFF : 8'h00;
    endcase
    return g;
  endfunction

  logic [7:0] pipe [LAT];

  // Lookup followed by LAT-1 extra register stages
  always_ff @(posedge clk) begin
    pipe[0] <= glyph(addr);
    for (int i = 1; i < LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign data = pipe[LAT-1];

endmodule

// File: rtl/vga_text_overlay_cell_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// A same-cycle read and write of one address returns the old contents.
module text_cell_ram #(
  parameter int DEPTH = 2400,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_text_overlay.sv
// Character-cell text overlay between the 640x480 timing controller and the VGA pins.
// Output (vga, hs_out, vs_out) lags the controller by 2+ROM_LAT pixel clocks.
module vga_text_overlay
  import vga_text_pkg::*;
#(
  parameter int         H_CHARS      = 80,
  parameter int         V_CHARS      = 30,
  parameter int         ROM_LAT      = 1,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [6:0] CLR_CHAR     = 7'h20
) (
  input  logic                pixel_clk,
  input  logic                rst,
  input  logic [10:0]         hcount,
  input  logic [10:0]         vcount,
  input  logic                blank,
  input  logic                hs_in,
  input  logic                vs_in,
  vga_text_overlay_if.slave   wr,
  input  logic                clr_req,
  output logic                busy,
  input  logic [11:0]         bg_color,
  output logic                hs_out,
  output logic                vs_out,
  output logic [11:0]         vga
);

  localparam int CELLS  = H_CHARS * V_CHARS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int L      = 2 + ROM_LAT;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CW_LOG = $clog2(CELL_W);
  localparam int CH_LOG = $clog2(CELL_H);

  clr_state_t            state, state_nx;
  logic [ADDR_W-1:0]     clr_addr, clr_addr_nx;
  logic                  wr_fire, wr_in_range, wr_err_r;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_waddr, ram_raddr;
  logic [CELL_BITS-1:0]  ram_wdata, cell_q;
  logic [10-CW_LOG:0]    col;
  logic [10-CH_LOG:0]    row;
  pix_ctl_t              ctl_in;
  pix_ctl_t              ctl_pipe [L];
  logic [2:0]            attr_pipe [ROM_LAT];
  logic [7:0]            font_word;
  logic                  pix_on;
  logic                  vs_prev, blink_phase;
  logic [FC_W-1:0]       frame_cnt;

  // ---------------- write bus / clear FSM ----------------
  assign wr.wr_ready = (state == ST_IDLE) && !clr_req;
  assign wr.wr_err   = wr_err_r;
  assign busy        = (state == ST_CLEAR);
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign wr_in_range = (int'(wr.wr_col) < H_CHARS) && (int'(wr.wr_row) < V_CHARS);

  // Clear FSM state register
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      wr_err_r <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      wr_err_r <= wr_fire && !wr_in_range;
    end
  end

  // Next state and buffer write-port steering
  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = {3'b000, CLR_CHAR};
        if (clr_addr == ADDR_W'(CELLS - 1)) begin
          state_nx    = ST_IDLE;
          clr_addr_nx = '0;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nx    = ST_CLEAR;
          clr_addr_nx = '0;
        end else if (wr_fire && wr_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = ADDR_W'(int'(wr.wr_row) * H_CHARS + int'(wr.wr_col));
          ram_wdata = {wr.wr_attr, wr.wr_char};
        end else begin
          ram_we = 1'b0;
        end
      end
      default: begin
        state_nx    = ST_CLEAR;
        clr_addr_nx = '0;
      end
    endcase
  end

  // ---------------- render pipeline ----------------
  assign col = hcount[10:CW_LOG];
  assign row = vcount[10:CH_LOG];

  // S0 decode; the buffer address is clamped to 0 outside the text area
  always_comb begin
    ctl_in.hs      = hs_in;
    ctl_in.vs      = vs_in;
    ctl_in.blank   = blank;
    ctl_in.in_area = (int'(col) < H_CHARS) && (int'(row) < V_CHARS);
    ctl_in.px      = hcount[2:0];
    ctl_in.line    = vcount[3:0];
    if (ctl_in.in_area) begin
      ram_raddr = ADDR_W'(int'(row) * H_CHARS + int'(col));
    end else begin
      ram_raddr = '0;
    end
  end

  text_cell_ram #(.DEPTH(CELLS), .WIDTH(CELL_BITS)) u_cell_ram (
    .clk   (pixel_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (cell_q)
  );

  font_rom #(.LAT(ROM_LAT)) u_font_rom (
    .clk  (pixel_clk),
    .addr ({cell_q[CHAR_LSB +: CHAR_W], ctl_pipe[0].line}),
    .data (font_word)
  );

  // Sync/control delay line (L stages) and attribute delay matching the ROM
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        ctl_pipe[i] <= '{hs: 1'b1, vs: 1'b1, blank: 1'b1, in_area: 1'b0, px: 3'd0, line: 4'd0};
      end
      for (int i = 0; i < ROM_LAT; i++) begin
        attr_pipe[i] <= 3'b000;
      end
    end else begin
      ctl_pipe[0] <= ctl_in;
      for (int i = 1; i < L; i++) begin
        ctl_pipe[i] <= ctl_pipe[i-1];
      end
      attr_pipe[0] <= cell_q[BLINK_BIT:FG_LSB];
      for (int i = 1; i < ROM_LAT; i++) begin
        attr_pipe[i] <= attr_pipe[i-1];
      end
    end
  end

  assign pix_on = font_word[~ctl_pipe[L-2].px] && !(attr_pipe[ROM_LAT-1][2] && blink_phase);

  // Final pixel mux; the vga register is stage L, aligned with ctl_pipe[L-1]
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vga <= 12'h000;
    end else if (ctl_pipe[L-2].blank) begin
      vga <= 12'h000;
    end else if (!ctl_pipe[L-2].in_area) begin
      vga <= bg_color;
    end else if (pix_on) begin
      vga <= palette(attr_pipe[ROM_LAT-1][1:0]);
    end else begin
      vga <= bg_color;
    end
  end

  assign hs_out = ctl_pipe[L-1].hs;
  assign vs_out = ctl_pipe[L-1].vs;

  // Blink timebase, counted on falling edges of the controller VS
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vs_prev     <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      if (vs_prev && !vs_in) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_overlay.sv
// Directed self-checking bench for vga_text_overlay (ROM_LAT=1 and a ROM_LAT=2 twin).
module tb_vga_text_overlay;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, vcount;
  logic        blank, hs_in, vs_in, clr_req;
  logic [11:0] bg_color;
  logic        busy, hs_out, vs_out, busy2, hs_out2, vs_out2;
  logic [11:0] vga, vga2;
  logic [7:0]  a_glyph [16];
  int          checks = 0;
  int          failures = 0;

  always #20 pixel_clk = ~pixel_clk;

  vga_text_overlay_if wif ();
  vga_text_overlay_if wif2 ();

  assign wif2.wr_valid = wif.wr_valid;
  assign wif2.wr_col   = wif.wr_col;
  assign wif2.wr_row   = wif.wr_row;
  assign wif2.wr_char  = wif.wr_char;
  assign wif2.wr_attr  = wif.wr_attr;

  vga_text_overlay dut (
    .pixel_clk (pixel_clk), .rst (rst), .hcount (hcount), .vcount (vcount),
    .blank (blank), .hs_in (hs_in), .vs_in (vs_in), .wr (wif.slave),
    .clr_req (clr_req), .busy (busy), .bg_color (bg_color),
    .hs_out (hs_out), .vs_out (vs_out), .vga (vga)
  );

  vga_text_overlay #(.ROM_LAT(2)) dut2 (
    .pixel_clk (pixel_clk), .rst (rst), .hcount (hcount), .vcount (vcount),
    .blank (blank), .hs_in (hs_in), .vs_in (vs_in), .wr (wif2.slave),
    .clr_req (clr_req), .busy (busy2), .bg_color (bg_color),
    .hs_out (hs_out2), .vs_out (vs_out2), .vga (vga2)
  );

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic write_cell(input logic [6:0] c, input logic [4:0] r,
                            input logic [6:0] ch, input logic [2:0] at);
    wif.wr_valid = 1'b1;
    wif.wr_col   = c;
    wif.wr_row   = r;
    wif.wr_char  = ch;
    wif.wr_attr  = at;
    step();
    wif.wr_valid = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input logic bl, output logic [11:0] v);
    hcount = 11'(x);
    vcount = 11'(y);
    blank  = bl;
    step(); step(); step();
    v = vga;
    blank = 1'b0;
  endtask

  task automatic vs_pulse();
    vs_in = 1'b0;
    step();
    vs_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; hs_in = 1'b0; hcount = 11'd0; vcount = 11'd0;
    step(); step(); step();
    checks++; if (vga !== 12'h000) begin failures++; $display("FAIL reset_vga got=%h exp=000", vga); end
    checks++; if (hs_out !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b exp=1", hs_out); end
    checks++; if (vs_out !== 1'b1) begin failures++; $display("FAIL reset_vs got=%b exp=1", vs_out); end
    checks++; if (wif.wr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", wif.wr_ready); end
    checks++; if (wif.wr_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", wif.wr_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    hs_in = 1'b1;
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      clr_req = (n == 1200);   // ignored while clearing
      step();
      n++;
    end
    clr_req = 1'b0;
    checks++; if (n !== 2400) begin failures++; $display("FAIL clear_len got=%0d exp=2400", n); end
    checks++; if (wif.wr_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", wif.wr_ready); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL clear_len2 busy2=%b exp=0", busy2); end
  endtask

  task automatic test_cleared_screen();
    logic [11:0] v;
    int xs [4] = '{0, 100, 639, 650};
    int ys [4] = '{0, 50, 479, 10};
    for (int k = 0; k < 4; k++) begin
      probe(xs[k], ys[k], 1'b0, v);
      checks++;
      if (v !== 12'h333) begin failures++; $display("FAIL cleared_px%0d got=%h exp=333", k, v); end
    end
  endtask

  task automatic test_glyph_scan();
    int n = 256;
    logic [11:0] exp;
    int x, y, j;
    checks++; if (wif.wr_ready !== 1'b1) begin failures++; $display("FAIL write_ready got=%b exp=1", wif.wr_ready); end
    write_cell(7'd0, 5'd1, 7'h41, 3'b000);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        hcount = 11'(i % 16);
        vcount = 11'(16 + i / 16);
        hs_in  = ((i % 7) != 3);
      end
      step();
      if (i >= 2) begin
        j = i - 2;
        x = j % 16;
        y = j / 16;
        exp = (x < 8 && a_glyph[y][7 - x]) ? 12'h0F0 : 12'h333;
        checks++;
        if (vga !== exp) begin failures++; $display("FAIL glyph_px x=%0d y=%0d got=%h exp=%h", x, y + 16, vga, exp); end
        checks++;
        if (hs_out !== ((j % 7) != 3) || vs_out !== 1'b1) begin
          failures++; $display("FAIL sync_align j=%0d got hs=%b vs=%b exp hs=%b vs=1", j, hs_out, vs_out, ((j % 7) != 3));
        end
      end
    end
    hs_in = 1'b1;
  endtask

  task automatic test_blink();
    logic [11:0] v;
    write_cell(7'd5, 5'd2, 7'h41, 3'b110);
    probe(40, 39, 1'b0, v);
    checks++; if (v !== 12'hFFF) begin failures++; $display("FAIL blink_f0 got=%h exp=FFF", v); end
    for (int k = 0; k < 29; k++) vs_pulse();
    probe(40, 39, 1'b0, v);
    checks++; if (v !== 12'hFFF) begin failures++; $display("FAIL blink_f29 got=%h exp=FFF", v); end
    vs_pulse();
    probe(40, 39, 1'b0, v);
    checks++; if (v !== 12'h333) begin failures++; $display("FAIL blink_f30 got=%h exp=333", v); end
    probe(0, 23, 1'b0, v);
    checks++; if (v !== 12'h0F0) begin failures++; $display("FAIL noblink_f30 got=%h exp=0F0", v); end
    for (int k = 0; k < 29; k++) vs_pulse();
    probe(40, 39, 1'b0, v);
    checks++; if (v !== 12'h333) begin failures++; $display("FAIL blink_f59 got=%h exp=333", v); end
    vs_pulse();
    probe(40, 39, 1'b0, v);
    checks++; if (v !== 12'hFFF) begin failures++; $display("FAIL blink_f60 got=%h exp=FFF", v); end
  endtask

  task automatic test_out_of_range();
    logic [11:0] v;
    write_cell(7'd80, 5'd0, 7'h00, 3'b010);
    checks++; if (wif.wr_err !== 1'b1) begin failures++; $display("FAIL err_col got=%b exp=1", wif.wr_err); end
    step();
    checks++; if (wif.wr_err !== 1'b0) begin failures++; $display("FAIL err_col_pulse got=%b exp=0", wif.wr_err); end
    write_cell(7'd0, 5'd30, 7'h00, 3'b010);
    checks++; if (wif.wr_err !== 1'b1) begin failures++; $display("FAIL err_row got=%b exp=1", wif.wr_err); end
    step();
    checks++; if (wif.wr_err !== 1'b0) begin failures++; $display("FAIL err_row_pulse got=%b exp=0", wif.wr_err); end
    probe(0, 23, 1'b0, v);
    checks++; if (v !== 12'h0F0) begin failures++; $display("FAIL oor_nochange got=%h exp=0F0", v); end
  endtask

  task automatic test_blank_latency();
    logic [11:0] v;
    probe(0, 23, 1'b1, v);
    checks++; if (v !== 12'h000) begin failures++; $display("FAIL blank_black got=%h exp=000", v); end
    hcount = 11'd8; vcount = 11'd23;
    step(); step(); step(); step();
    hcount = 11'd0;
    step();
    hcount = 11'd8;
    step();
    checks++; if (vga !== 12'h333) begin failures++; $display("FAIL lat1_early got=%h exp=333", vga); end
    step();
    checks++; if (vga !== 12'h0F0) begin failures++; $display("FAIL lat1_hit got=%h exp=0F0", vga); end
    checks++; if (vga2 !== 12'h333) begin failures++; $display("FAIL lat2_early got=%h exp=333", vga2); end
    step();
    checks++; if (vga !== 12'h333) begin failures++; $display("FAIL lat1_after got=%h exp=333", vga); end
    checks++; if (vga2 !== 12'h0F0) begin failures++; $display("FAIL lat2_hit got=%h exp=0F0", vga2); end
  endtask

  task automatic test_clear_collision();
    logic [11:0] v;
    int n;
    wif.wr_valid = 1'b1; wif.wr_col = 7'd3; wif.wr_row = 5'd3;
    wif.wr_char = 7'h41; wif.wr_attr = 3'b001;
    clr_req = 1'b1;
    #1;
    checks++; if (wif.wr_ready !== 1'b0) begin failures++; $display("FAIL clr_blocks_write got=%b exp=0", wif.wr_ready); end
    step();
    clr_req = 1'b0; wif.wr_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", busy); end
    for (int k = 0; k < 1000; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
    checks++; if (n !== 2400) begin failures++; $display("FAIL reclear_len got=%0d exp=2400", n); end
    probe(0, 23, 1'b0, v);
    checks++; if (v !== 12'h333) begin failures++; $display("FAIL reclear_px got=%h exp=333", v); end
    probe(24, 55, 1'b0, v);
    checks++; if (v !== 12'h333) begin failures++; $display("FAIL dropped_write_px got=%h exp=333", v); end
  endtask

  initial begin
    a_glyph = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; hcount = 11'd0; vcount = 11'd0; blank = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; clr_req = 1'b0; bg_color = 12'h333;
    wif.wr_valid = 1'b0; wif.wr_col = 7'd0; wif.wr_row = 5'd0;
    wif.wr_char = 7'd0; wif.wr_attr = 3'd0;
    test_reset();
    test_cleared_screen();
    test_glyph_scan();
    test_blink();
    test_out_of_range();
    test_blank_latency();
    test_clear_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_overlay.md
Name: vga_text_overlay

Overview:
- Parametrised character-cell text renderer: successor to the fixed-message VGA display block.
- Sits between vga_controller_640_60 (consumes hcount/vcount/blank/HS/VS) and the VGA pins.
- Holds a writable character buffer with per-cell colour/blink attributes and a pipelined font-ROM fetch.
- Outputs sync-aligned 12-bit RGB, so status text comes from logic instead of hard-coded ROM address windows.

Parameters:
- H_CHARS, 80, text columns (8-pixel cells).
- V_CHARS, 30, text rows (16-pixel cells).
- ROM_LAT, 1, font ROM read latency in cycles (1 or 2).
- BLINK_FRAMES, 30, frames per blink phase.
- CLR_CHAR, 7'h20, code written by clear.

Ports:
- pixel_clk  in  1  25 MHz pixel clock.
- rst  in  1  synchronous active-high reset.
- hcount  in  11  pixel column from the controller.
- vcount  in  11  pixel line from the controller.
- blank  in  1  controller blank.
- hs_in  in  1  controller HS.
- vs_in  in  1  controller VS (active low).
- wr_valid  in  1  cell-write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_col  in  7  target column.
- wr_row  in  5  target row.
- wr_char  in  7  ASCII code.
- wr_attr  in  3  {blink, fg_idx[1:0]}.
- wr_err  out  1  one-cycle pulse when an accepted write is out of range.
- clr_req  in  1  pulse: fill buffer with CLR_CHAR, attr 0.
- busy  out  1  clear in progress.
- bg_color  in  12  background colour.
- hs_out  out  1  HS delayed to match vga.
- vs_out  out  1  VS delayed to match vga.
- vga  out  12  RGB {B[11:8], G[7:4], R[3:0]}.

Behaviour:
- Reset values: vga=0, hs_out=1, vs_out=1, wr_ready=0, wr_err=0, busy=1. The FSM enters CLEAR with the clear address at 0.
- Clear FSM has two states, IDLE and CLEAR.
  - CLEAR writes one cell per cycle, address 0 to H_CHARS*V_CHARS-1 (2400 cycles by default), then goes to IDLE.
  - busy=1 and wr_ready=0 throughout CLEAR.
  - clr_req in IDLE enters CLEAR on the next cycle. clr_req during CLEAR is ignored.
  - rst mid-clear restarts the clear at address 0.
- IDLE: wr_ready=1.
  - On an accepted write with wr_col<H_CHARS and wr_row<V_CHARS, the cell at wr_row*H_CHARS+wr_col is written in the same edge.
  - An out-of-range write is dropped and wr_err pulses on the next cycle.
  - clr_req and wr_valid in the same IDLE cycle: clear wins and the write is not accepted (wr_ready drops combinationally on clr_req).
- Buffer: H_CHARS*V_CHARS x 10 bits, one write port and one read port, synchronous read.
  - A read and a write to the same cell in the same cycle returns the old data.
- Render pipeline, fixed latency L = 2 + ROM_LAT (3 by default):
  - S0: col = hcount[10:3], row = vcount[10:4], bit = hcount[2:0], line = vcount[3:0]. Register these with in_area = (col<H_CHARS && row<V_CHARS).
  - S1: buffer read.
  - S2: font_rom address = {char, line}.
  - The last stage registers vga.
  - hs_in, vs_in, blank, in_area and bit are delayed through a shift register of exactly L stages, so hs_out, vs_out and vga remain mutually aligned.
- Pixel selection, in priority order:
  - delayed blank → 0 (black, not red).
  - !in_area → bg_color.
  - font_word[~bit] && !(blink && blink_phase) → palette[fg_idx].
  - otherwise → bg_color.
- Palette:
  - 0 green 12'h0F0.
  - 1 red 12'h00F.
  - 2 white 12'hFFF.
  - 3 yellow 12'h0FF.
- Blink:
  - frame_cnt increments on the falling edge of vs_in.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - Reset: frame_cnt=0, blink_phase=0.

Decomposition:
- Package vga_text_pkg holds:
  - palette constants.
  - CELL_W=8, CELL_H=16.
  - attribute field offsets.
  - the FSM state enum.
- Natural sub-module: text_cell_ram (parametrised depth/width, one write and one sync read port).
- The existing font_rom is reused unmodified.

Test Plan:
- Reset, then idle 2400 cycles → busy=1 for exactly 2400 cycles, then wr_ready=1. Every cell then reads 0x20/attr 0 and the active area shows bg_color=12'h333.
- Write col 0 row 1 char 0x41 attr 3'b000; scan frame → pixels x0–7, y16–31 match the font_rom 'A' glyph in 12'h0F0, else 12'h333. vga lags hcount by 3 cycles, with hs_out/vs_out equally delayed.
- Write col 5 row 2 attr 3'b110 → the glyph is white for 30 frames, bg for the next 30, white again at frame 60.
- Write col 80 row 0, then col 0 row 30 → no buffer change, wr_err pulses once per write.
- wr_valid held with clr_req in the same IDLE cycle → write not accepted, busy rises next cycle. A rst asserted at clear address 1000 restarts the clear, and busy lasts 2400 more cycles.
- ROM_LAT=2 build → latency 4. During blank, vga=0 regardless of buffer contents.
